// File: rtl/ast_tensor_job_sequencer_sv.sv
// ast_tensor_job_sequencer_sv: streams A and B into the tensor array, starts it, drains X.
// Optional `AST_SEQ_ERRCHK_EN rejects jobs whose dimensions are 0 or exceed SIZE.
module ast_tensor_job_sequencer_sv #(
  parameter int DATAWIDTH = 14,
  parameter int SIZE      = 4,
  parameter int ADDRW     = 10,
  parameter int DW        = $clog2(SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DW-1:0]        cmd_q,
  input  logic [DW-1:0]        cmd_r,
  input  logic [DW-1:0]        cmd_k,
  input  logic [ADDRW-1:0]     cmd_a_base,
  input  logic [ADDRW-1:0]     cmd_b_base,
  input  logic [ADDRW-1:0]     cmd_x_base,
  input  logic                 cmd_relu,
  output logic [ADDRW-1:0]     mem_addr,
  output logic                 mem_ren,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 mem_wen,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic [DW-1:0]        ts_depth,
  output logic [DW-1:0]        ts_width,
  output logic [DATAWIDTH-1:0] ts_data_in,
  output logic                 ts_wen,
  output logic                 ts_set,
  output logic                 ts_relu,
  output logic                 ts_start,
  output logic                 ts_ren,
  input  logic                 ts_busy,
  input  logic                 ts_done,
  input  logic [DATAWIDTH-1:0] ts_data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CW = 2 * DW;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   q_q, r_q, k_q;
  logic [ADDRW-1:0] a_q, b_q, x_q;
  logic            relu_q, push_q, set_q, done_q;
  logic [CW-1:0]   qr, rk, qk;
  logic [CW:0]     cnt_inc;
  logic            accept, bad, last_a, last_x;
  logic            unused_ts_busy;

  assign unused_ts_busy = ts_busy;

  assign qr      = CW'(q_q) * CW'(r_q);
  assign rk      = CW'(r_q) * CW'(k_q);
  assign qk      = CW'(q_q) * CW'(k_q);
  assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
  assign last_a  = cnt_inc >= {1'b0, qr};
  assign last_x  = cnt_inc >= {1'b0, qk};
  assign accept  = cmd_valid & (state_q == S_IDLE);

`ifdef AST_SEQ_ERRCHK_EN
  logic err_q;

  assign bad = (cmd_q == '0) | (cmd_r == '0) | (cmd_k == '0) |
               (cmd_q > DW'(SIZE)) | (cmd_r > DW'(SIZE)) |
               (cmd_k > DW'(SIZE));

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= accept & bad;
  end

  assign err = err_q;
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !bad) begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
        end
      end
      S_LOAD_A: begin
        if (last_a) begin
          state_d = S_LOAD_B;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // One extra cycle at cnt==rk lets the final B element be pushed.
      S_LOAD_B: begin
        if (cnt_q < rk) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (ts_done) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (last_x) state_d = S_IDLE;
        else        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    ts_start   = (state_q == S_START);
    ts_relu    = relu_q & (state_q != S_IDLE);
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    ts_ren     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == S_LOAD_A && cnt_q < qr) begin
      mem_ren  = 1'b1;
      mem_addr = a_q + ADDRW'(cnt_q);
    end
    if (state_q == S_LOAD_B && cnt_q < rk) begin
      mem_ren  = 1'b1;
      mem_addr = b_q + ADDRW'(cnt_q);
    end
    if (state_q == S_DRAIN && cnt_q < qk) begin
      mem_wen   = 1'b1;
      ts_ren    = 1'b1;
      mem_addr  = x_q + ADDRW'(cnt_q);
      mem_wdata = ts_data_out;
    end
    ts_wen     = push_q;
    ts_set     = push_q & set_q;
    ts_data_in = push_q ? mem_rdata : '0;
    ts_depth   = '0;
    ts_width   = '0;
    if (push_q) begin
      ts_depth = set_q ? k_q : r_q;
      ts_width = set_q ? r_q : q_q;
    end
    done = done_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      r_q    <= '0;
      k_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      x_q    <= '0;
      relu_q <= 1'b0;
      push_q <= 1'b0;
      set_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        q_q    <= cmd_q;
        r_q    <= cmd_r;
        k_q    <= cmd_k;
        a_q    <= cmd_a_base;
        b_q    <= cmd_b_base;
        x_q    <= cmd_x_base;
        relu_q <= cmd_relu;
      end
      push_q <= mem_ren;
      set_q  <= (state_q == S_LOAD_B);
      done_q <= (state_q == S_DRAIN) & last_x;
    end
  end

endmodule

// File: tb/tb_ast_tensor_job_sequencer_sv.sv
// Testbench for ast_tensor_job_sequencer_sv: memory model, behavioural tensor array,
// job vector table and hand-written reset / zero-dimension sequences.
module tb_ast_tensor_job_sequencer_sv;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, cmd_relu;
  logic [2:0]  cmd_q, cmd_r, cmd_k;
  logic [9:0]  cmd_a_base, cmd_b_base, cmd_x_base, mem_addr;
  logic        mem_ren, mem_wen;
  logic [13:0] mem_rdata = '0;
  logic [13:0] mem_wdata, ts_data_in;
  logic [2:0]  ts_depth, ts_width;
  logic        ts_wen, ts_set, ts_relu, ts_start, ts_ren;
  logic        ts_busy = 1'b0;
  logic        ts_done = 1'b0;
  logic [13:0] ts_data_out = '0;
  logic        busy, done, err;

  ast_tensor_job_sequencer_sv dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_q(cmd_q), .cmd_r(cmd_r), .cmd_k(cmd_k),
    .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base),
    .cmd_x_base(cmd_x_base), .cmd_relu(cmd_relu),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .ts_depth(ts_depth), .ts_width(ts_width), .ts_data_in(ts_data_in),
    .ts_wen(ts_wen), .ts_set(ts_set), .ts_relu(ts_relu),
    .ts_start(ts_start), .ts_ren(ts_ren),
    .ts_busy(ts_busy), .ts_done(ts_done), .ts_data_out(ts_data_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [13:0] mem [0:1023];
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  int cur_q, cur_r, cur_k, tw;
  bit cur_relu;
  bit clr_req = 1'b0;
  int na = 0, nb = 0, dimerr = 0, nstart = 0, ndone = 0, nerr = 0;
  int nren = 0, overlap = 0, idle_strobe = 0, relu_bad = 0;
  int t_done = 0, dcount = 0;
  int qa[$], qb[$], rq[$], wa[$], wd[$];

  function automatic int sx(input logic [13:0] d);
    return int'($signed(d));
  endfunction

  // Behavioural tensor array plus bus monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    int s, ea, eb;
    ts_done = 1'b0;
    if (clr_req) begin
      qa.delete(); qb.delete(); rq.delete(); dcount = 0;
    end
    if (dcount > 0) begin
      dcount--;
      if (dcount == 0) ts_done = 1'b1;
    end
    if (ts_wen) begin
      if (!ts_set) begin
        qa.push_back(sx(ts_data_in)); na++;
        if (ts_depth != 3'(cur_r) || ts_width != 3'(cur_q)) dimerr++;
      end else begin
        qb.push_back(sx(ts_data_in)); nb++;
        if (ts_depth != 3'(cur_k) || ts_width != 3'(cur_r)) dimerr++;
      end
    end
    if (ts_start) begin
      nstart++;
      for (int i = 0; i < cur_q; i++)
        for (int j = 0; j < cur_k; j++) begin
          s = 0;
          for (int r = 0; r < cur_r; r++) begin
            ea = (i*cur_r + r < qa.size()) ? qa[i*cur_r + r] : 0;
            eb = (r*cur_k + j < qb.size()) ? qb[r*cur_k + j] : 0;
            s += ea * eb;
          end
          if (ts_relu && s < 0) s = 0;
          rq.push_back(s & 'h3fff);
        end
      qa.delete(); qb.delete();
      dcount = tw + 1;
    end
    if (mem_ren) nren++;
    if (mem_ren && mem_wen) overlap++;
    if (!busy && (ts_wen | ts_ren | ts_start | mem_ren | mem_wen)) idle_strobe++;
    if (done) begin ndone++; t_done = cyc; end
    if (err) nerr++;
    if (ts_ren && ts_relu != cur_relu) relu_bad++;
    if (mem_wen) begin
      wa.push_back(int'(mem_addr)); wd.push_back(int'(mem_wdata));
    end
    if (ts_ren && rq.size() > 0) void'(rq.pop_front());
    ts_data_out = (rq.size() > 0) ? 14'(rq[0]) : '0;
  end

  typedef struct {
    int q, r, k, ab, bb, xb;
    bit relu;
    int wt;
    int a[12];
    int b[12];
    int x[12];
  } vec_t;
  vec_t v[5];

  int ntests = 0, nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic setv(input int i, q, r, k, ab, bb, xb,
                      input bit relu, input int wt);
    v[i].q = q; v[i].r = r; v[i].k = k;
    v[i].ab = ab; v[i].bb = bb; v[i].xb = xb;
    v[i].relu = relu; v[i].wt = wt;
  endtask

  task automatic issue(input int q, r, k, ab, bb, xb,
                       input bit relu, output int tacc);
    int n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    cmd_q = 3'(q); cmd_r = 3'(r); cmd_k = 3'(k);
    cmd_a_base = 10'(ab); cmd_b_base = 10'(bb); cmd_x_base = 10'(xb);
    cmd_relu = relu; cmd_valid = 1'b1;
    step();
    tacc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int tacc, n, na0, nb0, de0, ns0, nd0, nw0, rb0, qrn, rkn, qkn;
    qrn = v[i].q * v[i].r; rkn = v[i].r * v[i].k; qkn = v[i].q * v[i].k;
    cur_q = v[i].q; cur_r = v[i].r; cur_k = v[i].k;
    cur_relu = v[i].relu; tw = v[i].wt;
    for (int j = 0; j < qrn; j++) mem[(v[i].ab + j) % 1024] = 14'(v[i].a[j]);
    for (int j = 0; j < rkn; j++) mem[(v[i].bb + j) % 1024] = 14'(v[i].b[j]);
    na0 = na; nb0 = nb; de0 = dimerr; ns0 = nstart;
    nd0 = ndone; nw0 = wa.size(); rb0 = relu_bad;
    issue(v[i].q, v[i].r, v[i].k, v[i].ab, v[i].bb, v[i].xb, v[i].relu, tacc);
    // A different command offered while busy must be ignored.
    cmd_q = 3'd3; cmd_r = 3'd3; cmd_k = 3'd3; cmd_x_base = 10'd500;
    cmd_valid = 1'b1;
    repeat (3) step();
    cmd_valid = 1'b0;
    n = 0;
    while (ndone == nd0 && n < 300) begin step(); n++; end
    repeat (2) step();
    chk($sformatf("v%0d_done_cnt", i), ndone - nd0, 1);
    chk($sformatf("v%0d_latency", i), t_done - tacc,
        qrn + rkn + 1 + (v[i].wt + 1) + qkn + 1);
    chk($sformatf("v%0d_a_push", i), na - na0, qrn);
    chk($sformatf("v%0d_b_push", i), nb - nb0, rkn);
    chk($sformatf("v%0d_dims", i), dimerr - de0, 0);
    chk($sformatf("v%0d_start", i), nstart - ns0, 1);
    chk($sformatf("v%0d_relu", i), relu_bad - rb0, 0);
    chk($sformatf("v%0d_wr_cnt", i), wa.size() - nw0, qkn);
    for (int j = 0; j < qkn; j++) begin
      if (nw0 + j < wa.size()) begin
        chk($sformatf("v%0d_addr%0d", i, j), wa[nw0 + j], (v[i].xb + j) % 1024);
        chk($sformatf("v%0d_data%0d", i, j), wd[nw0 + j], v[i].x[j] & 'h3fff);
      end
    end
  endtask

  initial begin
    int tacc, n, nd0, nw0, ns0, ne0, nr0, bsy;
    logic [14:0] outs;
    reset = 1'b1; cmd_valid = 1'b0; cmd_relu = 1'b0;
    cmd_q = '0; cmd_r = '0; cmd_k = '0;
    cmd_a_base = '0; cmd_b_base = '0; cmd_x_base = '0;
    cur_q = 0; cur_r = 0; cur_k = 0; cur_relu = 1'b0; tw = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    setv(0, 2, 2, 2, 0, 16, 32, 1'b0, 0);
    v[0].a = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0};
    v[0].b = '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
    v[0].x = '{19, 22, 43, 50, 0, 0, 0, 0, 0, 0, 0, 0};
    setv(1, 1, 4, 3, 100, 120, 200, 1'b0, 3);
    v[1].a = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0};
    v[1].b = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1};
    v[1].x = '{5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    setv(2, 1, 1, 1, 300, 301, 0, 1'b1, 1);
    v[2].a = '{-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[2].b = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[2].x = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    setv(3, 2, 1, 2, 400, 410, 1023, 1'b0, 0);
    v[3].a = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[3].b = '{3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[3].x = '{3, 4, 6, 8, 0, 0, 0, 0, 0, 0, 0, 0};
    setv(4, 2, 2, 1, 420, 430, 440, 1'b0, 2);
    v[4].a = '{-2, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    v[4].b = '{4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[4].x = '{7, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    repeat (3) step();
    outs = {busy, done, err, mem_ren, mem_wen, ts_wen, ts_set, ts_relu,
            ts_start, ts_ren, |mem_addr, |mem_wdata, |ts_depth,
            |ts_width, |ts_data_in};
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_outs", int'(outs), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_vec(i);

    // Reset while waiting on the tensor array; its late done is ignored.
    cur_q = 1; cur_r = 1; cur_k = 1; cur_relu = 1'b0; tw = 2;
    mem[600] = 14'd2; mem[601] = 14'd5;
    nd0 = ndone; nw0 = wa.size(); ns0 = nstart;
    issue(1, 1, 1, 600, 601, 700, 1'b0, tacc);
    n = 0;
    while (nstart == ns0 && n < 50) begin step(); n++; end
    chk("wr_start_seen", nstart - ns0, 1);
    step();
    reset = 1'b1;
    step();
    outs = {busy, done, err, mem_ren, mem_wen, ts_wen, ts_set, ts_relu,
            ts_start, ts_ren, |mem_addr, |mem_wdata, |ts_depth,
            |ts_width, |ts_data_in};
    chk("wr_rst_ready", int'(cmd_ready), 1);
    chk("wr_rst_outs", int'(outs), 0);
    reset = 1'b0;
    repeat (10) step();
    chk("wr_no_done", ndone - nd0, 0);
    chk("wr_no_write", wa.size() - nw0, 0);
    chk("wr_idle", int'(busy), 0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;

    // Zero inner dimension.
    cur_q = 1; cur_r = 0; cur_k = 1; cur_relu = 1'b0; tw = 0;
    nd0 = ndone; nw0 = wa.size(); ne0 = nerr; nr0 = nren;
`ifdef AST_SEQ_ERRCHK_EN
    issue(1, 0, 1, 800, 810, 820, 1'b0, tacc);
    bsy = int'(busy);
    repeat (6) begin step(); bsy += int'(busy); end
    chk("zr_err", nerr - ne0, 1);
    chk("zr_busy", bsy, 0);
    chk("zr_no_ren", nren - nr0, 0);
    chk("zr_no_done", ndone - nd0, 0);
`else
    issue(1, 0, 1, 800, 810, 820, 1'b0, tacc);
    bsy = 0;
    n = 0;
    while (ndone == nd0 && n < 100) begin step(); n++; end
    repeat (2) step();
    chk("zr_err", nerr - ne0, 0);
    chk("zr_done", ndone - nd0, 1);
    chk("zr_no_ren", nren - nr0, 0);
    chk("zr_wr_cnt", wa.size() - nw0, 1);
    if (wa.size() > nw0) chk("zr_addr", wa[nw0], 820);
`endif

    chk("ren_wen_overlap", overlap, 0);
    chk("idle_strobes", idle_strobe, 0);
    chk("dims_total", dimerr, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
